fmult_bank: RTL
===============

Name: fmult_bank

Overview:
- Upstream feeder of the predictor accumulator in the ADPCM encode/decode path.
- Computes the eight G.726 FMULT partial products (WB1..WB6 = Bn x DQn, WA1..WA2 = An x SRn) serially on one shared floating-multiply datapath.
- Presents all eight products simultaneously on double-buffered outputs, then pulses start_trig so the accumulator can walk them.

Parameters:
- NPROD, 8, number of products per frame (fixed; 6 zero-predictor + 2 pole-predictor).

Ports:
- clk  in  1  system clock, all state on rising edge
- rstn  in  1  asynchronous active-low reset
- start  in  1  single-cycle request; samples all operands
- A1,A2  in  16 each  pole coefficients, two's complement
- B1..B6  in  16 each  zero coefficients, two's complement
- SR1,SR2  in  11 each  reconstructed signal, float {sign, exp[3:0], mant[5:0]}
- DQ1..DQ6  in  11 each  quantized difference, same float format
- WA1,WA2,WB1..WB6  out  16 each  products, two's complement
- start_trig  out  1  one-cycle pulse: new product set valid (drives accumulator start_trig)
- busy  out  1  high while a frame is in progress

Behaviour:
- Reset (async, any time incl. mid-frame): all eight outputs = 0x0000, start_trig=0, busy=0, FSM=IDLE, operand snapshot and pipeline registers cleared. The in-flight frame is discarded.
- FSM states: IDLE, ISSUE, DRAIN.
  - IDLE: start=1 at edge T0 snapshots all 16 operands, sets busy, idx=0, goes to ISSUE.
  - ISSUE: edges T1..T8 issue idx 0..7 into stage 1 in order B1/DQ1..B6/DQ6, A1/SR1, A2/SR2. After idx 7 the FSM goes to DRAIN.
  - DRAIN: at T9 stage 2 writes the last product, all eight internal results are copied to the output registers at once, start_trig=1 and busy=0, FSM returns to IDLE.
- start_trig is high only between T9 and T10. Outputs change only at T9 and are otherwise stable, so they hold for at least 10 cycles, which covers the accumulator's 8-state walk.
- start while busy is ignored; operand snapshot is unaffected. start in the cycle right after start_trig is accepted (back-to-back frames, period 10 cycles). Operand changes after T0 have no effect on the current frame.
- Stage 1 (coefficient normalise), per coefficient C:
  - CS = C[15]
  - CMAG = (CS ? (65536 - C) : C) >> 2, truncated to 13 bits
  - CEXP = 0 if CMAG == 0, else MSB index + 1 (range 0..13)
  - CMANT = 32 if CMAG == 0, else (CMAG << 6) >> CEXP (6 bits)
  - Register the float operand alongside.
- Stage 2 (multiply/denormalise):
  - WS = CS ^ FS
  - WEXP = CEXP + FEXP (5 bits)
  - WMANT = (CMANT * FMANT + 48) >> 4 (8 bits)
  - WMAG = WEXP > 26 ? ((WMANT << 7) << (WEXP - 26)) & 0x7FFF : (WMANT << 7) >> (26 - WEXP)
  - W = WS ? (65536 - WMAG) mod 65536 : WMAG
- Overflow bits above bit 14 of WMAG are discarded, not saturated. Negative zero magnitude yields 0x0000.
- Latency: start edge to start_trig rising = 9 clocks. Throughput is 1 product per clock.

Test Plan:
- Reset mid-frame: pulse start, assert rstn=0 at T4 → outputs 0x0000, start_trig never pulses, busy=0; a fresh start after release completes normally at T9.
- Nominal: all B = A = 0x4000, all DQ = SR = 0x160 → all eight outputs 0x0021, start_trig high for exactly one cycle at T9, busy high T0..T9.
- Sign/zero mix: B1=0xC000, B2=0x0000, B3=0x7FFF with DQ3=0x3FF, others 0x4000/0x160; DQ1=DQ2=0x160 → WB1=0xFFDF, WB2=0x0000, WB3=0x7600 (wrap case), others 0x0021.
- Ordering: distinct coefficients per slot (e.g. Bn = n*0x1000, An = 0x4000 + n*0x800) against a software FMULT model → each output matches its own slot; no two slots swapped.
- Busy/start handling: second start at T5 is ignored (single trig at T9); start at T10 with new operands → outputs unchanged T10..T18 and update at T19 with a single pulse.
- Operand hold: change all inputs at T1 → results reflect the T0 snapshot.

Source files
------------

// File: rtl/fmult_bank.sv
// Serial G.726 FMULT bank: eight partial products (WB1..WB6, WA1..WA2) computed on one
// two-stage float-multiply pipe, then published together with a one-cycle start_trig.
module fmult_bank (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic [15:0] A1,
  input  logic [15:0] A2,
  input  logic [15:0] B1,
  input  logic [15:0] B2,
  input  logic [15:0] B3,
  input  logic [15:0] B4,
  input  logic [15:0] B5,
  input  logic [15:0] B6,
  input  logic [10:0] SR1,
  input  logic [10:0] SR2,
  input  logic [10:0] DQ1,
  input  logic [10:0] DQ2,
  input  logic [10:0] DQ3,
  input  logic [10:0] DQ4,
  input  logic [10:0] DQ5,
  input  logic [10:0] DQ6,
  output logic [15:0] WA1,
  output logic [15:0] WA2,
  output logic [15:0] WB1,
  output logic [15:0] WB2,
  output logic [15:0] WB3,
  output logic [15:0] WB4,
  output logic [15:0] WB5,
  output logic [15:0] WB6,
  output logic        start_trig,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t      state, state_nxt;
  logic        snap_en, issue_en, load_out;
  logic [2:0]  idx_q;
  logic [15:0] coef_q [8];
  logic [10:0] flt_q  [8];
  logic [15:0] res_q  [7];
  logic [15:0] out_q  [8];
  logic        trig_q;

  logic        s1_valid;
  logic [2:0]  s1_idx;
  logic        s1_cs;
  logic [3:0]  s1_cexp;
  logic [5:0]  s1_cmant;
  logic [10:0] s1_flt;

  logic [15:0] c_sel;
  logic [10:0] f_sel;
  logic        c_cs;
  logic [15:0] c_mag16;
  logic [12:0] c_mag;
  logic [3:0]  c_exp;
  logic [5:0]  c_mant;

  logic        w_s;
  logic [4:0]  w_exp;
  logic [11:0] w_prod;
  logic [11:0] w_sum;
  logic [7:0]  w_mant;
  logic [14:0] w_m15;
  logic [14:0] w_mag;
  logic [15:0] w;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ISSUE;
      ISSUE:   if (idx_q == 3'd7) state_nxt = DRAIN;
      DRAIN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    snap_en  = (state == IDLE) && start;
    issue_en = (state == ISSUE);
    load_out = (state == DRAIN);
    busy     = (state != IDLE);
  end

  // Stage 1: normalise the selected coefficient into sign / exponent / 6-bit mantissa
  always_comb begin
    c_sel   = coef_q[idx_q];
    f_sel   = flt_q[idx_q];
    c_cs    = c_sel[15];
    c_mag16 = c_cs ? (16'd0 - c_sel) : c_sel;
    c_mag   = 13'(c_mag16 >> 2);
    c_exp   = '0;
    for (int i = 0; i < 13; i++)
      if (c_mag[i]) c_exp = 4'(i + 1);
    c_mant  = (c_mag == '0) ? 6'd32 : 6'({c_mag, 6'b0} >> c_exp);
  end

  // Stage 2: multiply and denormalise; bits above 14 are dropped, not saturated
  always_comb begin
    w_s    = s1_cs ^ s1_flt[10];
    w_exp  = {1'b0, s1_cexp} + {1'b0, s1_flt[9:6]};
    w_prod = {6'b0, s1_cmant} * {6'b0, s1_flt[5:0]};
    w_sum  = w_prod + 12'd48;
    w_mant = 8'(w_sum >> 4);
    w_m15  = {w_mant, 7'b0};
    if (w_exp > 5'd26) w_mag = w_m15 << (w_exp - 5'd26);
    else               w_mag = w_m15 >> (5'd26 - w_exp);
    w      = w_s ? (16'd0 - {1'b0, w_mag}) : {1'b0, w_mag};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      idx_q    <= '0;
      s1_valid <= 1'b0;
      s1_idx   <= '0;
      s1_cs    <= 1'b0;
      s1_cexp  <= '0;
      s1_cmant <= '0;
      s1_flt   <= '0;
      trig_q   <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        coef_q[i] <= '0;
        flt_q[i]  <= '0;
        out_q[i]  <= '0;
      end
      for (int i = 0; i < 7; i++) res_q[i] <= '0;
    end else begin
      trig_q   <= load_out;
      s1_valid <= issue_en;
      if (snap_en) begin
        idx_q     <= '0;
        coef_q[0] <= B1;  coef_q[1] <= B2;  coef_q[2] <= B3;
        coef_q[3] <= B4;  coef_q[4] <= B5;  coef_q[5] <= B6;
        coef_q[6] <= A1;  coef_q[7] <= A2;
        flt_q[0]  <= DQ1; flt_q[1]  <= DQ2; flt_q[2]  <= DQ3;
        flt_q[3]  <= DQ4; flt_q[4]  <= DQ5; flt_q[5]  <= DQ6;
        flt_q[6]  <= SR1; flt_q[7]  <= SR2;
      end
      if (issue_en) begin
        idx_q    <= idx_q + 3'd1;
        s1_idx   <= idx_q;
        s1_cs    <= c_cs;
        s1_cexp  <= c_exp;
        s1_cmant <= c_mant;
        s1_flt   <= f_sel;
      end
      if (s1_valid && (s1_idx != 3'd7)) res_q[s1_idx] <= w;
      // Last product bypasses res_q so all eight outputs change on the same edge
      if (load_out) begin
        for (int i = 0; i < 7; i++) out_q[i] <= res_q[i];
        out_q[7] <= w;
      end
    end
  end

  assign start_trig = trig_q;
  assign WB1 = out_q[0];
  assign WB2 = out_q[1];
  assign WB3 = out_q[2];
  assign WB4 = out_q[3];
  assign WB5 = out_q[4];
  assign WB6 = out_q[5];
  assign WA1 = out_q[6];
  assign WA2 = out_q[7];

endmodule
